// File: rtl/video_in_gate.sv
// rtl/video_in_gate.sv - video input gate, playback start detector and frame decimator; VIDIN_MEAS_EN adds active-size measurement
module video_in_gate #(
    parameter int         DW        = 24,
    parameter int         DECIM     = 2,
    parameter logic [3:0] START_THR = 4'hE,
    parameter bit         HS_POL    = 1'b0,
    parameter bit         VS_POL    = 1'b0,
    parameter int         CNT_W     = 12
) (
    input  logic             iclk,
    input  logic             s_rst_n,
    input  logic             rx_over,
    input  logic             cfg_done,
    input  logic [DW-1:0]    vid_data,
    input  logic             vid_hs,
    input  logic             vid_vs,
    input  logic             vid_de,
    output logic [DW-1:0]    out_data,
    output logic             out_hs,
    output logic             out_vs,
    output logic             out_de,
    output logic             play_en,
    output logic             frame_keep,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_active,
    output logic             meas_valid
);
    localparam int              PH_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    typedef enum logic [1:0] {S_IDLE, S_BRIGHT, S_PLAY} state_t;

    state_t          state;
    logic            arm;
    logic            gate;
    logic            gate_q;
    logic            vs_d;
    logic            vs_rise;
    logic            sof;
    logic [3:0]      fp;
    logic [3:0]      fp_last;
    logic            fp_valid;
    logic            fp_valid_last;
    logic [DW-1:0]   fp_pix;
    logic [DW-1:0]   fp_pix_last;
    logic [PH_W-1:0] phase;
    logic [PH_W-1:0] phase_nxt;

    assign gate      = arm & cfg_done;
    assign vs_rise   = out_vs & ~vs_d;
    assign phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);

    // Receiver-ready latch: once armed, stays armed until reset
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n)     arm <= 1'b0;
        else if (rx_over) arm <= 1'b1;
    end

    // Output stage: gated, polarity-normalised copy of the input; gate_q tracks the gate as seen by this stage
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            out_data <= '0;
            out_hs   <= 1'b0;
            out_vs   <= 1'b0;
            out_de   <= 1'b0;
            gate_q   <= 1'b0;
        end else begin
            gate_q <= gate;
            if (gate) begin
                out_data <= vid_data;
                out_hs   <= vid_hs ^ ~HS_POL;
                out_vs   <= vid_vs ^ ~VS_POL;
                out_de   <= vid_de;
            end else begin
                out_data <= '0;
                out_hs   <= 1'b0;
                out_vs   <= 1'b0;
                out_de   <= 1'b0;
            end
        end
    end

    // Start-of-frame pulse, one cycle after the normalised vsync rising edge
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            vs_d <= 1'b0;
            sof  <= 1'b0;
        end else begin
            vs_d <= out_vs;
            sof  <= vs_rise;
        end
    end

    // First-pixel capture; the previous frame's capture is snapshotted at vsync rise so the FSM sees it at sof
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            fp            <= '0;
            fp_valid      <= 1'b0;
            fp_pix        <= '0;
            fp_last       <= '0;
            fp_valid_last <= 1'b0;
            fp_pix_last   <= '0;
        end else begin
            if (vs_rise) begin
                fp_last       <= fp;
                fp_valid_last <= fp_valid;
                fp_pix_last   <= fp_pix;
            end
            if (out_vs || sof) begin
                fp       <= '0;
                fp_valid <= 1'b0;
                fp_pix   <= '0;
            end else if (out_de && !fp_valid) begin
                fp       <= out_data[DW-1:DW-4];
                fp_valid <= 1'b1;
                fp_pix   <= out_data;
            end
        end
    end

    // Playback detection FSM plus decimation phase, keep flag and kept-frame counter
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state      <= S_IDLE;
            play_en    <= 1'b0;
            phase      <= '0;
            frame_keep <= 1'b1;
            frame_cnt  <= '0;
        end else if (!gate_q) begin
            state      <= S_IDLE;
            play_en    <= 1'b0;
            phase      <= '0;
            frame_keep <= 1'b1;
        end else if (sof) begin
            case (state)
                S_IDLE: begin
                    if (fp_valid_last && (fp_last >= START_THR)) state <= S_BRIGHT;
                end
                S_BRIGHT: begin
                    if (fp_valid_last && (fp_last < START_THR) && (fp_pix_last != '0)) begin
                        state      <= S_PLAY;
                        play_en    <= 1'b1;
                        phase      <= '0;
                        frame_keep <= 1'b1;
                        frame_cnt  <= frame_cnt + CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    phase      <= phase_nxt;
                    frame_keep <= (phase_nxt == '0);
                    if (phase_nxt == '0) frame_cnt <= frame_cnt + CNT_W'(1);
                end
                default: begin
                    state   <= S_IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef VIDIN_MEAS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             de_d;
    logic             line_done;
    logic             sof_seen;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;

    // Active-size measurement: first-line width and de-line count, published at each sof after the first
    always_ff @(posedge iclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            de_d       <= 1'b0;
            line_done  <= 1'b0;
            sof_seen   <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            h_active   <= '0;
            v_active   <= '0;
            meas_valid <= 1'b0;
        end else begin
            de_d       <= out_de;
            meas_valid <= 1'b0;
            if (!gate_q) sof_seen <= 1'b0;
            if (sof) begin
                if (gate_q) begin
                    sof_seen <= 1'b1;
                    if (sof_seen) begin
                        h_active   <= hcnt;
                        v_active   <= vcnt;
                        meas_valid <= 1'b1;
                    end
                end
                hcnt      <= '0;
                vcnt      <= '0;
                line_done <= 1'b0;
            end else begin
                if (out_de && !line_done && (hcnt != CNT_MAX)) hcnt <= hcnt + CNT_W'(1);
                if (de_d && !out_de)                           line_done <= 1'b1;
                if (out_de && !de_d && (vcnt != CNT_MAX))      vcnt <= vcnt + CNT_W'(1);
            end
        end
    end
`else
    assign h_active   = '0;
    assign v_active   = '0;
    assign meas_valid = 1'b0;
`endif

endmodule

// File: tb/tb_video_in_gate.sv
// tb/tb_video_in_gate.sv - randomized scoreboard bench for video_in_gate
module tb_video_in_gate;
    localparam int         DW    = 24;
    localparam int         DECIM = 3;
    localparam int         CNT_W = 12;
    localparam logic [3:0] THR   = 4'hE;

    logic             iclk = 1'b0;
    logic             s_rst_n;
    logic             rx_over;
    logic             cfg_done;
    logic [DW-1:0]    vid_data;
    logic             vid_hs;
    logic             vid_vs;
    logic             vid_de;
    logic [DW-1:0]    out_data;
    logic             out_hs;
    logic             out_vs;
    logic             out_de;
    logic             play_en;
    logic             frame_keep;
    logic [CNT_W-1:0] frame_cnt;
    logic [CNT_W-1:0] h_active;
    logic [CNT_W-1:0] v_active;
    logic             meas_valid;

    video_in_gate #(
        .DW(DW), .DECIM(DECIM), .START_THR(THR), .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(CNT_W)
    ) dut (
        .iclk(iclk), .s_rst_n(s_rst_n), .rx_over(rx_over), .cfg_done(cfg_done),
        .vid_data(vid_data), .vid_hs(vid_hs), .vid_vs(vid_vs), .vid_de(vid_de),
        .out_data(out_data), .out_hs(out_hs), .out_vs(out_vs), .out_de(out_de),
        .play_en(play_en), .frame_keep(frame_keep), .frame_cnt(frame_cnt),
        .h_active(h_active), .v_active(v_active), .meas_valid(meas_valid)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    always @(posedge iclk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct { logic [DW-1:0] d; int c; } pix_t;
    typedef struct { bit play; bit keep; int cnt; } frm_t;
    typedef struct { int h; int v; } meas_t;

    pix_t  pixq[$];
    frm_t  frmq[$];
    meas_t measq[$];

    int n_cmp = 0;
    int n_bad = 0;
    int quiet_bad = 0;
    bit mon_en = 1'b0;
`ifdef VIDIN_MEAS_EN
    bit meas_on = 1'b1;
`else
    bit meas_on = 1'b0;
`endif

    // reference model state
    bit            arm_m = 1'b0;
    bit            m_bright = 1'b0;
    bit            m_play = 1'b0;
    int            m_k = 0;
    int            m_cnt = 0;
    bit            m_fpv = 1'b0;
    logic [DW-1:0] m_fp = '0;
    bit            m_seen = 1'b0;
    bit            m_first = 1'b1;
    int            m_h = 0;
    int            m_v = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: output event with no expectation queued (cycle %0d)", name, cyc);
    endtask

    function automatic logic [DW-1:0] rnd_px();
        return DW'($urandom);
    endfunction

    function automatic logic [DW-1:0] px_nib(input logic [3:0] nib);
        logic [DW-1:0] p;
        p = rnd_px();
        p[DW-1 -: 4] = nib;
        return p;
    endfunction

    function automatic bit gate_m();
        return arm_m && cfg_done;
    endfunction

    task automatic drive(input logic vs, input logic hs, input logic de, input logic [DW-1:0] d);
        pix_t p;
        vid_vs = vs; vid_hs = hs; vid_de = de; vid_data = d;
        if (gate_m() && de) begin
            p.d = d; p.c = cyc;
            pixq.push_back(p);
            if (!m_fpv) begin m_fpv = 1'b1; m_fp = d; end
        end
        @(posedge iclk); #1;
    endtask

    task automatic vsync();
        frm_t  f;
        meas_t m;
        if (gate_m()) begin
            if (m_play) begin
                m_k++;
                if (m_k % DECIM == 0) m_cnt++;
            end else if (!m_bright) begin
                if (m_fpv && (m_fp[DW-1 -: 4] >= THR)) m_bright = 1'b1;
            end else if (m_fpv && (m_fp[DW-1 -: 4] < THR) && (m_fp != '0)) begin
                m_play = 1'b1; m_k = 0; m_cnt++;
            end
            f.play = m_play;
            f.keep = !m_play || (m_k % DECIM == 0);
            f.cnt  = m_cnt;
            frmq.push_back(f);
            if (meas_on) begin
                if (m_seen) begin m.h = m_h; m.v = m_v; measq.push_back(m); end
                m_seen = 1'b1;
            end
            m_fpv = 1'b0; m_h = 0; m_v = 0; m_first = 1'b1;
        end
        drive(1'b0, 1'b1, 1'b0, rnd_px());
        drive(1'b0, 1'b1, 1'b0, rnd_px());
        repeat (3) drive(1'b1, 1'b1, 1'b0, rnd_px());
    endtask

    task automatic line(input int w, input logic [DW-1:0] first_px, input bit use_first);
        repeat (2) drive(1'b1, 1'b0, 1'b0, rnd_px());
        repeat (2) drive(1'b1, 1'b1, 1'b0, rnd_px());
        if (gate_m()) begin
            m_v++;
            if (m_first) begin m_h = w; m_first = 1'b0; end
        end
        for (int i = 0; i < w; i++) drive(1'b1, 1'b1, 1'b1, (i == 0 && use_first) ? first_px : rnd_px());
        repeat (2) drive(1'b1, 1'b1, 1'b0, rnd_px());
    endtask

    task automatic frame(input logic [DW-1:0] first_px, input int w, input int h);
        vsync();
        for (int l = 0; l < h; l++) line(w, first_px, l == 0);
        repeat (2) drive(1'b1, 1'b1, 1'b0, rnd_px());
    endtask

    task automatic frame_drop();
        bit play_before;
        vsync();
        repeat (2) drive(1'b1, 1'b0, 1'b0, rnd_px());
        repeat (2) drive(1'b1, 1'b1, 1'b0, rnd_px());
        repeat (3) drive(1'b1, 1'b1, 1'b1, rnd_px());
        play_before = m_play;
        cfg_done = 1'b0;
        m_bright = 1'b0; m_play = 1'b0; m_k = 0; m_seen = 1'b0;
        drive(1'b1, 1'b1, 1'b1, rnd_px());
        @(negedge iclk);
        check("drop_out_de", out_de, 0);
        check("drop_out_data", out_data, 0);
        check("drop_out_vs", out_vs, 0);
        check("drop_out_hs", out_hs, 0);
        check("drop_play_en_hold", play_en, play_before);
        @(negedge iclk);
        check("drop_play_en_fall", play_en, 0);
        @(posedge iclk); #1;
        repeat (5) drive(1'b1, 1'b1, 1'b1, rnd_px());
        line(6, rnd_px(), 1'b0);
        repeat (4) drive(1'b1, 1'b1, 1'b0, rnd_px());
        cfg_done = 1'b1;
        repeat (4) drive(1'b1, 1'b1, 1'b0, rnd_px());
    endtask

    task automatic monitor();
        logic  vs_p = 1'b0;
        logic  hs_p = 1'b0;
        int    vs_len = 0;
        int    hs_len = 0;
        int    chk_at = -1;
        pix_t  p;
        frm_t  f;
        meas_t m;
        forever begin
            @(negedge iclk);
            if (mon_en) begin
                if (!arm_m && (out_de || out_vs || out_hs || out_data != '0)) quiet_bad++;
                if (out_de) begin
                    if (pixq.size() == 0) unexpected("pix_unexpected");
                    else begin
                        p = pixq.pop_front();
                        check("pix_data", out_data, p.d);
                        check("pix_latency", cyc, p.c + 1);
                    end
                end
                if (out_vs && !vs_p) begin
                    vs_len = 0;
                    if (frmq.size() == 0) unexpected("sof_unexpected");
                    else chk_at = cyc + 2;
                end
                if (out_vs) vs_len++;
                if (!out_vs && vs_p) check("vs_width", vs_len, 2);
                if (out_hs && !hs_p) hs_len = 0;
                if (out_hs) hs_len++;
                if (!out_hs && hs_p) check("hs_width", hs_len, 2);
                if (cyc == chk_at) begin
                    f = frmq.pop_front();
                    check("play_en", play_en, f.play);
                    check("frame_keep", frame_keep, f.keep);
                    check("frame_cnt", frame_cnt, f.cnt % (1 << CNT_W));
                    chk_at = -1;
                end
                if (meas_valid) begin
                    if (measq.size() == 0) unexpected("meas_unexpected");
                    else begin
                        m = measq.pop_front();
                        check("h_active", h_active, m.h);
                        check("v_active", v_active, m.v);
                    end
                end
                vs_p = out_vs;
                hs_p = out_hs;
            end
        end
    endtask

    initial begin
        int sel;
        logic [DW-1:0] fpx;
        s_rst_n = 1'b0; rx_over = 1'b0; cfg_done = 1'b0;
        vid_hs = 1'b1; vid_vs = 1'b1; vid_de = 1'b0; vid_data = '0;
        repeat (3) @(posedge iclk);
        #1;
        check("rst_out_data", out_data, 0);
        check("rst_out_syncs", {out_hs, out_vs, out_de}, 0);
        check("rst_play_en", play_en, 0);
        check("rst_frame_keep", frame_keep, 1);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_meas", {h_active, v_active, meas_valid}, 0);
        s_rst_n = 1'b1;
        mon_en = 1'b1;
        fork monitor(); join_none

        // configured but never armed: nothing may pass
        cfg_done = 1'b1;
        repeat (3) frame(24'hF0F0F0, 6, 3);
        check("gate_closed_quiet", quiet_bad, 0);
        check("gate_closed_play_en", play_en, 0);

        // arm with pixels already flowing: first gated sample two cycles after rx_over
        rx_over = 1'b1;
        drive(1'b1, 1'b1, 1'b1, px_nib(4'h0));
        rx_over = 1'b0;
        arm_m = 1'b1;
        repeat (4) drive(1'b1, 1'b1, 1'b1, px_nib(4'h0));
        repeat (3) drive(1'b1, 1'b1, 1'b0, rnd_px());

        // start detection with a zero-pixel frame inside the bright leader, then decimation
        frame(24'hF0F0F0, 8, 4);
        frame(24'hF0F0F0, 8, 4);
        frame(24'h000000, 8, 4);
        frame(24'h404040, 8, 4);
        for (int i = 0; i < 8; i++) frame(px_nib(4'(1 + $urandom_range(0, 12))), 8, 4);

        frame_drop();

        // detection restarts from idle
        frame(px_nib(4'hF), 5, 2);
        frame(24'h404040, 5, 2);
        for (int i = 0; i < 16; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       fpx = px_nib(4'hE + 4'($urandom_range(0, 1)));
                1:       fpx = rnd_px();
                2:       fpx = '0;
                default: fpx = px_nib(4'($urandom_range(1, 13)));
            endcase
            frame(fpx, $urandom_range(2, 10), $urandom_range(1, 4));
        end
        frame(px_nib(4'hF), 4, 2);
        frame(24'h404040, 4, 2);
        vsync();
        repeat (6) drive(1'b1, 1'b1, 1'b0, rnd_px());
        check("end_pix_queue", pixq.size(), 0);
        check("end_frame_queue", frmq.size(), 0);
        check("end_meas_queue", measq.size(), 0);
        check("end_play_en", play_en, 1);

        // asynchronous reset in the middle of active video
        repeat (3) drive(1'b1, 1'b1, 1'b1, rnd_px());
        mon_en = 1'b0;
        #2 s_rst_n = 1'b0;
        #1;
        check("async_rst_play_en", play_en, 0);
        check("async_rst_frame_cnt", frame_cnt, 0);
        check("async_rst_frame_keep", frame_keep, 1);
        check("async_rst_out", {out_data, out_hs, out_vs, out_de}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/video_in_gate.md
# video_in_gate

Parametrised video-input gate and frame selector between the HDMI receiver and the downstream frame-buffer/tracker path. It normalises sync polarity and holds video off until the link is armed and configured. It detects the start of real playback from a bright-leader-then-content first-pixel pattern, then keeps one frame in every DECIM frames. Optionally it measures active width and height per frame.

## Interface
- DW, 24, pixel data width (≥4)
- DECIM, 2, keep 1 of DECIM frames once playing (≥1)
- START_THR, 4'hE, top-nibble threshold for "bright" first pixel
- HS_POL, 0, input HS active level (0 = active-low)
- VS_POL, 0, input VS active level (0 = active-low)
- CNT_W, 12, width of frame/measurement counters
- iclk  in  1  pixel clock; all inputs synchronous to it
- s_rst_n  in  1  reset s_rst_n, asynchronous, active-low; clock iclk
- rx_over  in  1  pulse: receiver set-up finished (sticky-latched)
- cfg_done  in  1  level: downstream configuration complete
- vid_data  in  DW  pixel data
- vid_hs / vid_vs / vid_de  in  1 each  raw syncs and data enable
- out_data  out  DW  registered gated pixel
- out_hs / out_vs / out_de  out  1 each  registered, active-high syncs and de
- play_en  out  1  playback detected (sticky)
- frame_keep  out  1  1 = current frame kept, 0 = dropped
- frame_cnt  out  CNT_W  kept-frame count, wraps
- h_active / v_active  out  CNT_W  de pixels on first line / de lines of last frame
- meas_valid  out  1  one-cycle pulse when h_active/v_active update

## Operation
- arm: set by rx_over, cleared only by reset. gate = arm & cfg_done.
- Stage 1: when gate=1, out_data<=vid_data, out_hs<=vid_hs^~HS_POL, out_vs<=vid_vs^~VS_POL, out_de<=vid_de. When gate=0, all four <=0.
- sof: one-cycle pulse on the rising edge of out_vs, from a 1-cycle delayed copy of out_vs.
- first pixel: fp_valid and fp cleared while out_vs=1. On the first out_de=1 cycle with fp_valid=0, fp<=out_data[DW-1:DW-4] and fp_valid<=1.
- FSM (evaluated at sof, using the previous frame's fp/fp_valid):
  - IDLE -> BRIGHT when fp_valid and fp≥START_THR.
  - BRIGHT -> PLAY when fp_valid, fp<START_THR, and the full captured pixel is nonzero. Otherwise stay in BRIGHT.
  - PLAY is sticky.
  - gate=0 forces IDLE in any state, checked before sof handling.
- play_en = (state==PLAY), registered.
- Decimation phase, 0..DECIM-1:
  - On the sof that enters PLAY: phase<=0, frame_keep<=1, frame_cnt<=frame_cnt+1.
  - On later sofs in PLAY: phase wraps DECIM-1->0, frame_keep<=(next phase==0), frame_cnt increments when next phase==0.
  - Outside PLAY: frame_keep=1 and phase=0.
  - DECIM=1 gives frame_keep constantly 1.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset values: out_* 0, play_en 0, frame_keep 1, frame_cnt 0, h_active 0, v_active 0, meas_valid 0, state IDLE, arm 0.
- Data latency: input to out_* is 1 cycle. sof is high 2 cycles after the normalised vid_vs assertion.
- play_en, frame_keep, and frame_cnt update the cycle after sof.
- rx_over and cfg_done both high in the same cycle: the gate opens the cycle after arm sets, so the first gated sample is 2 cycles after rx_over.
- cfg_done dropping mid-frame: out_* are 0 from the next cycle; FSM goes to IDLE and play_en falls 1 cycle later.
- sof in the same cycle as the first de: sof wins and fp stays cleared.
- Reset mid-frame: all state returns to reset values asynchronously.

## Configuration
- VIDIN_MEAS_EN defined: measurement logic is compiled in.
  - hcnt counts out_de cycles of the first de line after sof. vcnt counts out_de rising edges. Both saturate at 2^CNT_W-1.
  - At each sof, if a previous sof has been seen since gate opened, h_active<=hcnt and v_active<=vcnt, and meas_valid pulses 1 cycle after sof.
- VIDIN_MEAS_EN undefined: h_active=0, v_active=0, meas_valid=0 constant, and no counter logic is instantiated.

## Test plan
- Gate: cfg_done=1 and rx_over never pulsed, 3 frames -> out_* all 0 and play_en 0. Then rx_over pulse -> out_data equals vid_data delayed 1 cycle.
- Polarity: VS_POL=0, HS_POL=0, vid_vs low for 2 cycles -> out_vs high for 2 cycles starting 1 cycle later, and one sof.
- Start detect: frames with first pixel 24'hF0F0F0, F0F0F0, 404040 -> play_en rises the cycle after the 4th sof, frame_keep=1, frame_cnt=1. A first pixel of 24'h000000 instead of 404040 -> stays in BRIGHT.
- Decimation: DECIM=3, 7 frames after PLAY -> frame_keep sequence 1,0,0,1,0,0,1 and frame_cnt ends at 3.
- cfg_done dropped mid-frame while in PLAY -> out_* 0 next cycle, play_en 0 two cycles later. Re-raise cfg_done -> start detection restarts from IDLE.
- VIDIN_MEAS_EN: 8×4 active frames -> h_active=8 and v_active=4 with a meas_valid pulse at the 2nd sof. Macro undefined -> meas_valid never asserts.
